// File: rtl/jk_bank_pkg.sv
// Shared definitions for the JK bank arbiter.
// Contents: JK op encodings, FSM state type, grant-id constants, and the
// single-bit JK next-state helper.
package jk_bank_pkg;

  // Op encoding is {j,k}
  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] CLR  = 2'b01;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] TGL  = 2'b11;

  localparam logic GID_A = 1'b0;
  localparam logic GID_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic jk_bit(input logic [1:0] op, input logic q);
    case (op)
      CLR:     jk_bit = 1'b0;
      SET:     jk_bit = 1'b1;
      TGL:     jk_bit = ~q;
      default: jk_bit = q;
    endcase
  endfunction

endpackage

// File: rtl/jk_bank_arb_if.sv
// Requester-side handshake bundle for jk_bank_arb.
// Each of the two requesters (a_*, b_*) has:
//   valid / ready  command handshake
//   op[1:0]        JK op {j,k}
//   mask[WIDTH]    bit-select for the op
//   done           one-cycle commit pulse
// master: the requesters' view.  slave: the controller's view.
interface jk_bank_arb_if #(parameter int WIDTH = 8);
  logic             a_valid;
  logic             a_ready;
  logic [1:0]       a_op;
  logic [WIDTH-1:0] a_mask;
  logic             a_done;

  logic             b_valid;
  logic             b_ready;
  logic [1:0]       b_op;
  logic [WIDTH-1:0] b_mask;
  logic             b_done;

  modport master (
    output a_valid, a_op, a_mask, b_valid, b_op, b_mask,
    input  a_ready, a_done, b_ready, b_done
  );

  modport slave (
    input  a_valid, a_op, a_mask, b_valid, b_op, b_mask,
    output a_ready, a_done, b_ready, b_done
  );
endinterface

// File: rtl/jk_rr_arb.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req[1:0]     request lines (bit 0 = A, bit 1 = B)
//   advance      grant was taken this cycle; remember who won
//   grant[1:0]   one-hot grant, zero when no request
// A lone requester always wins. On a tie, the requester not granted
// last wins. After reset, A has priority.
module jk_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // last_b = 1 means B was granted last, so A wins a tie.
  logic last_b;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_b ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)          last_b <= 1'b1;
    else if (advance) last_b <= grant[1];
  end

endmodule

// File: rtl/jk_bank_arb.sv
// Shared bank of WIDTH JK bit-cells, written by two requesters through a
// round-robin arbitrated IDLE -> APPLY -> DONE sequence.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        requester handshakes (jk_bank_arb_if.slave)
//   q          current bank state
//   busy       high whenever the FSM is not IDLE
//   q_par      XOR of q, registered with q (only with JK_BANK_PARITY_EN)
// Optional feature macro: JK_BANK_PARITY_EN.
// Timing: accept at cycle N, q updated and done high at N+2, next accept
// at N+3 at the earliest.
module jk_bank_arb
  import jk_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  jk_bank_arb_if.slave     bus,
  output logic [WIDTH-1:0] q,
  output logic             busy
`ifdef JK_BANK_PARITY_EN
  ,
  output logic             q_par
`endif
);

  state_t           state, state_nxt;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] mask_r;
  logic             gid_r;
  logic [WIDTH-1:0] q_nxt;
  logic [1:0]       grant;
  logic             accept;

  jk_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({bus.b_valid, bus.a_valid}),
    .advance (accept),
    .grant   (grant)
  );

  always_comb begin
    state_nxt   = state;
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
    bus.a_done  = 1'b0;
    bus.b_done  = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        bus.a_ready = grant[0];
        bus.b_ready = grant[1];
        accept      = (bus.a_valid & grant[0]) | (bus.b_valid & grant[1]);
        if (accept) state_nxt = APPLY;
      end
      APPLY: state_nxt = DONE;
      DONE: begin
        bus.a_done = (gid_r == GID_A);
        bus.b_done = (gid_r == GID_B);
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Per-bit JK cells; only masked bits move, and only in APPLY.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign q_nxt[i] = (state == APPLY && mask_r[i]) ? jk_bit(op_r, q[i]) : q[i];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      q      <= '0;
      op_r   <= HOLD;
      mask_r <= '0;
      gid_r  <= GID_A;
`ifdef JK_BANK_PARITY_EN
      q_par  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
`ifdef JK_BANK_PARITY_EN
      q_par <= ^q_nxt;
`endif
      if (accept) begin
        op_r   <= grant[1] ? bus.b_op   : bus.a_op;
        mask_r <= grant[1] ? bus.b_mask : bus.a_mask;
        gid_r  <= grant[1] ? GID_B : GID_A;
      end
    end
  end

endmodule

// File: tb/tb_jk_bank_arb.sv
// Self-checking bench for jk_bank_arb: a table of directed commands with
// hand-computed grant/q/parity, plus hand-written reset corner sequences.
// q_par checks are compiled in only with JK_BANK_PARITY_EN.
module tb_jk_bank_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] q;
  logic       busy;
`ifdef JK_BANK_PARITY_EN
  logic       q_par;
`endif

  int checks = 0;
  int errors = 0;

  jk_bank_arb_if #(.WIDTH(8)) bus ();

  jk_bank_arb #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .q    (q),
    .busy (busy)
`ifdef JK_BANK_PARITY_EN
    ,
    .q_par(q_par)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic [1:0] aop;
    logic [7:0] amask;
    logic       bv;
    logic [1:0] bop;
    logic [7:0] bmask;
    logic       egid;   // 0 = A expected to win, 1 = B
    logic [7:0] eq;
    logic       epar;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Entered and left at a negedge with the FSM in IDLE.
  task automatic do_vec(input vec_t v, input int idx);
    int w;
    bus.a_valid = v.av; bus.a_op = v.aop; bus.a_mask = v.amask;
    bus.b_valid = v.bv; bus.b_op = v.bop; bus.b_mask = v.bmask;
    #1;
    chk($sformatf("v%0d idle_busy", idx), busy, 0);
    chk($sformatf("v%0d idle_done", idx), {bus.a_done, bus.b_done}, 0);
    w = 0;
    while (!(bus.a_ready | bus.b_ready) && w < 4) begin
      @(negedge clk); #1; w++;
    end
    if (w >= 4) begin
      chk($sformatf("v%0d accept_timeout", idx), 0, 1);
      return;
    end
    chk($sformatf("v%0d ready{b,a}", idx), {bus.b_ready, bus.a_ready},
        v.egid ? 2'b10 : 2'b01);
    @(negedge clk); #1;  // APPLY
    chk($sformatf("v%0d apply_ready", idx), {bus.b_ready, bus.a_ready}, 0);
    chk($sformatf("v%0d apply_busy", idx), busy, 1);
    chk($sformatf("v%0d apply_done", idx), {bus.b_done, bus.a_done}, 0);
    @(negedge clk); #1;  // DONE
    chk($sformatf("v%0d q", idx), q, v.eq);
    chk($sformatf("v%0d done{b,a}", idx), {bus.b_done, bus.a_done},
        v.egid ? 2'b10 : 2'b01);
    chk($sformatf("v%0d done_ready", idx), {bus.b_ready, bus.a_ready}, 0);
`ifdef JK_BANK_PARITY_EN
    chk($sformatf("v%0d q_par", idx), q_par, v.epar);
`endif
    @(negedge clk);      // back to IDLE
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            av aop    amask  bv bop    bmask  gid q      par
    tbl[0]  = '{1, 2'b10, 8'h0F, 0, 2'b00, 8'h00, 0, 8'h0F, 0};
    tbl[1]  = '{1, 2'b11, 8'hFF, 1, 2'b01, 8'h03, 1, 8'h0C, 0};
    tbl[2]  = '{1, 2'b11, 8'hFF, 1, 2'b01, 8'h03, 0, 8'hF3, 0};
    tbl[3]  = '{1, 2'b11, 8'h0F, 1, 2'b10, 8'hF0, 1, 8'hF3, 0};
    tbl[4]  = '{1, 2'b11, 8'h0F, 1, 2'b01, 8'hC0, 0, 8'hFC, 0};
    tbl[5]  = '{1, 2'b00, 8'hFF, 1, 2'b01, 8'hC0, 1, 8'h3C, 0};
    tbl[6]  = '{1, 2'b00, 8'hFF, 1, 2'b11, 8'h81, 0, 8'h3C, 0};
    tbl[7]  = '{1, 2'b10, 8'h00, 1, 2'b11, 8'h81, 1, 8'hBD, 0};
    tbl[8]  = '{1, 2'b10, 8'h00, 1, 2'b01, 8'hFF, 0, 8'hBD, 0};
    tbl[9]  = '{0, 2'b00, 8'h00, 1, 2'b01, 8'hFF, 1, 8'h00, 0};
    tbl[10] = '{0, 2'b00, 8'h00, 1, 2'b10, 8'h06, 1, 8'h06, 0};
    tbl[11] = '{0, 2'b00, 8'h00, 1, 2'b01, 8'h06, 1, 8'h00, 0};
    tbl[12] = '{1, 2'b11, 8'h01, 0, 2'b00, 8'h00, 0, 8'h01, 1};
    tbl[13] = '{1, 2'b11, 8'h01, 0, 2'b00, 8'h00, 0, 8'h00, 0};
    tbl[14] = '{1, 2'b10, 8'h07, 0, 2'b00, 8'h00, 0, 8'h07, 1};
    tbl[15] = '{1, 2'b01, 8'h04, 0, 2'b00, 8'h00, 0, 8'h03, 0};

    rst = 1'b1;
    bus.a_valid = 0; bus.a_op = 0; bus.a_mask = 0;
    bus.b_valid = 0; bus.b_op = 0; bus.b_mask = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset q", q, 0);
    chk("reset busy", busy, 0);
    chk("reset ready", {bus.b_ready, bus.a_ready}, 0);
    chk("reset done", {bus.b_done, bus.a_done}, 0);
`ifdef JK_BANK_PARITY_EN
    chk("reset q_par", q_par, 0);
`endif
    @(negedge clk);

    for (int i = 0; i < 16; i++) do_vec(tbl[i], i);

    // Reset during APPLY: A wins, then rst kills the command.
    bus.a_valid = 1; bus.a_op = 2'b10; bus.a_mask = 8'hFF;
    bus.b_valid = 0;
    #1;
    chk("abort ready_a", bus.a_ready, 1);
    @(negedge clk);
    bus.a_valid = 0;
    rst = 1'b1;
    #1;
    chk("abort in_apply", busy, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort q", q, 0);
    chk("abort busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort no_done%0d", i), {bus.b_done, bus.a_done}, 0);
      chk($sformatf("abort q_hold%0d", i), q, 0);
      @(negedge clk); #1;
    end
    @(negedge clk);
    // Pointer was left at B-priority by the aborted A grant; reset restores A.
    do_vec('{1, 2'b10, 8'h81, 1, 2'b01, 8'hFF, 0, 8'h81, 0}, 100);

    // Reset overrides an accept in the same cycle.
    bus.a_valid = 1; bus.a_op = 2'b10; bus.a_mask = 8'hFF;
    bus.b_valid = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.a_valid = 0;
    #1;
    chk("rst_accept busy", busy, 0);
    chk("rst_accept q", q, 0);
    @(negedge clk); #1;
    chk("rst_accept q_after", q, 0);
    chk("rst_accept done", {bus.b_done, bus.a_done}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_bank_arb.md
JK_BANK_ARB -- requirements
Module: jk_bank_arb

Interface
REQ-001 Parameter WIDTH: default 8; number of JK bit-cells in the shared bank.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 a_valid  input  1  requester A command valid.
REQ-005 a_ready  output  1  controller accepts A's command this cycle.
REQ-006 a_op  input  2  A's JK op as {j,k}: 00 hold, 01 clear, 10 set, 11 toggle.
REQ-007 a_mask  input  WIDTH  A's bit-select; op applies only where mask=1.
REQ-008 a_done  output  1  one-cycle pulse: A's command committed to bank.
REQ-009 b_valid, b_ready, b_op, b_mask, b_done: same as REQ-004..008, for requester B.
REQ-010 q  output  WIDTH  current bank state.
REQ-011 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, APPLY, DONE.
REQ-013 IDLE: assert ready to at most one requester (the arbitration winner among valid ones); both readies low when neither is valid.
REQ-014 Accept = valid & ready; on accept, latch op, mask, grant id; next state APPLY.
REQ-015 Arbitration: round-robin; winner is the requester not granted last; after reset, A has priority.
REQ-016 Only one valid: that requester wins regardless of round-robin pointer; pointer still updates to it.
REQ-017 APPLY: for each bit i with mask[i]=1, q[i] next = JK function of latched op on q[i]; mask[i]=0 bits hold; next state DONE.
REQ-018 DONE: pulse done of the granted requester for one cycle; q already shows new value; next state IDLE.
REQ-019 Latency: accept at cycle N -> q updated and done high at cycle N+2; next accept possible earliest at N+3.
REQ-020 Readies SHALL be low in APPLY and DONE; valid held by requester during those states is not accepted.
REQ-021 op=00 or mask all-zero: full sequence still runs, done pulses, q unchanged.
REQ-022 a_done and b_done SHALL never be high in the same cycle.

Reset
REQ-023 rst high: next cycle state=IDLE, q=0, a_ready=b_ready=0, a_done=b_done=0, busy=0, round-robin pointer=A-priority.
REQ-024 rst during APPLY or DONE: in-flight command aborted, no done pulse, bank cleared.
REQ-025 rst overrides any accept in the same cycle.

Configuration
REQ-026 Macro JK_BANK_PARITY_EN defined: extra output q_par (1 bit) = XOR of q, registered with q, reset 0.
REQ-027 Macro undefined: q_par port absent; all other behaviour identical.

Structure
REQ-028 Shared package jk_bank_pkg SHALL hold op encoding constants (HOLD, CLR, SET, TGL), FSM state typedef, grant-id constants.
REQ-029 Round-robin two-way arbiter SHALL be a sub-module jk_rr_arb (inputs req[1:0], advance; output grant one-hot).

Verification
REQ-030 Reset then A: op=10 mask=0x0F -> q=0x0F at cycle accept+2, a_done pulse once, b_done stays 0.
REQ-031 From q=0x0F, A and B valid together, A op=11 mask=0xFF, B op=01 mask=0x03, after prior A grant -> B served first (q=0x0C), then A (q=0xF3).
REQ-032 Both valid continuously for 6 commands -> grants alternate B,A,B,A,B,A; no accept in APPLY/DONE.
REQ-033 op=11 mask=0x01 from q=0x00 twice -> q=0x01 then 0x00.
REQ-034 rst asserted in APPLY of set mask=0xFF -> q=0x00, no done, next A command accepted normally with A priority.
REQ-035 With JK_BANK_PARITY_EN: q=0x07 -> q_par=1; q=0x03 -> q_par=0.
